// File: rtl/mem_ctrl_mp_pkg.sv
// Shared definitions for the multi-port byte-serial memory controller:
// FSM encoding, length codes, transfer direction and the length decode.
package mem_ctrl_mp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Code 3 is reserved and behaves as a word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_mp_arb.sv
// Requester arbiter: fixed priority (highest index wins) or round-robin
// starting after the last granted port. Output grant is one-hot.
module mem_arb
  import mem_ctrl_mp_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_last,
  input  logic                 i_rr,
  output logic [NUM_PORTS-1:0] o_gnt
);

  logic w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    if (i_rr) begin
      // Scan offsets 1..NUM_PORTS from the last grant; the last grant itself is checked last.
      for (int unsigned off = 1; off <= NUM_PORTS; off++) begin
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
          if (!w_found && i_req[j] && (j == (32'(i_last) + off) % NUM_PORTS)) begin
            o_gnt[j] = 1'b1;
            w_found  = 1'b1;
          end
        end
      end
    end else begin
      for (int unsigned j = 0; j < NUM_PORTS; j++) begin
        if (i_req[j]) begin
          o_gnt    = '0;
          o_gnt[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_ctrl_mp.sv
// Multi-port memory controller: arbitrates byte/half/word reads and writes
// onto a byte-wide RAM, one byte per advancing cycle.
module mem_ctrl_mp
  import mem_ctrl_mp_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned ARB_RR    = 0
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic [NUM_PORTS-1:0]        req_in,
  input  logic [NUM_PORTS-1:0]        rw_in,
  input  logic [2*NUM_PORTS-1:0]      len_in,
  input  logic [NUM_PORTS-1:0]        sext_in,
  input  logic [ADDR_W*NUM_PORTS-1:0] addr_in,
  input  logic [32*NUM_PORTS-1:0]     wdata_in,
  input  logic [7:0]                  ram_data_in,
  output logic                        ram_rw_out,
  output logic [ADDR_W-1:0]           ram_addr_out,
  output logic [7:0]                  ram_data_out,
  output logic [NUM_PORTS-1:0]        busy_out,
  output logic [NUM_PORTS-1:0]        done_out,
  output logic [31:0]                 rdata_out
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_t                r_state, w_state_nxt;
  logic [2:0]            r_cnt;
  logic [NUM_PORTS-1:0]  r_gnt;
  logic [IDX_W-1:0]      r_last;
  logic                  r_rw;
  logic [1:0]            r_len;
  logic                  r_sext;
  logic [ADDR_W-1:0]     r_addr;
  logic [31:0]           r_wdata;
  logic [3:0][7:0]       r_cap;

  logic [NUM_PORTS-1:0]  w_gnt;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic                  w_any_req;
  logic                  w_sel_rw;
  logic [1:0]            w_sel_len;
  logic                  w_sel_sext;
  logic [ADDR_W-1:0]     w_sel_addr;
  logic [31:0]           w_sel_wdata;
  logic [2:0]            w_len_b;
  logic [31:0]           w_rd;

  assign w_any_req = |req_in;
  assign w_len_b   = len_bytes(r_len);

  mem_arb #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_arb (
    .i_req  (req_in),
    .i_last (r_last),
    .i_rr   (ARB_RR != 0),
    .o_gnt  (w_gnt)
  );

  always_comb begin
    w_gnt_idx   = '0;
    w_sel_rw    = 1'b0;
    w_sel_len   = '0;
    w_sel_sext  = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int unsigned j = 0; j < NUM_PORTS; j++) begin
      if (w_gnt[j]) begin
        w_gnt_idx   = IDX_W'(j);
        w_sel_rw    = rw_in[j];
        w_sel_len   = len_in[2*j +: 2];
        w_sel_sext  = sext_in[j];
        w_sel_addr  = addr_in[ADDR_W*j +: ADDR_W];
        w_sel_wdata = wdata_in[32*j +: 32];
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)      r_state <= IDLE;
    else if (rdy_in) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_state_nxt = (w_sel_rw == RW_WRITE) ? WRITE : READ;
      READ:    if (r_cnt == w_len_b) w_state_nxt = DONE;
      WRITE:   if (r_cnt == w_len_b - 3'd1) w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_last  <= IDX_W'(NUM_PORTS - 1);
      r_rw    <= 1'b0;
      r_len   <= '0;
      r_sext  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cap   <= '0;
    end else if (rdy_in) begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_gnt   <= w_gnt;
            r_last  <= w_gnt_idx;
            r_rw    <= w_sel_rw;
            r_len   <= w_sel_len;
            r_sext  <= w_sel_sext;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_cnt   <= '0;
            r_cap   <= '0;
          end
        end
        READ: begin
          // RAM answers one cycle late, so the byte on ram_data_in belongs to cnt-1.
          if (r_cnt != 3'd0) r_cap[r_cnt[1:0] - 2'd1] <= ram_data_in;
          if (r_cnt != w_len_b) r_cnt <= r_cnt + 3'd1;
        end
        WRITE:   r_cnt <= r_cnt + 3'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (r_len)
      LEN_BYTE: w_rd = {{24{r_sext & r_cap[0][7]}}, r_cap[0]};
      LEN_HALF: w_rd = {{16{r_sext & r_cap[1][7]}}, r_cap[1], r_cap[0]};
      default:  w_rd = r_cap;
    endcase
  end

  always_comb begin
    ram_rw_out   = 1'b0;
    ram_addr_out = '0;
    ram_data_out = '0;
    busy_out     = '0;
    done_out     = '0;
    rdata_out    = '0;
    case (r_state)
      READ: begin
        ram_addr_out = r_addr + ADDR_W'(r_cnt);
        busy_out     = r_gnt;
      end
      WRITE: begin
        ram_rw_out   = rdy_in;
        ram_addr_out = r_addr + ADDR_W'(r_cnt);
        ram_data_out = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
        busy_out     = r_gnt;
      end
      DONE: begin
        busy_out  = r_gnt;
        done_out  = r_gnt;
        rdata_out = (r_rw == RW_WRITE) ? '0 : w_rd;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl_mp.sv
// Bench for mem_ctrl_mp: directed scenarios plus random single-port traffic
// against a byte-array reference memory, and arbitration with RR and fixed priority.
module tb_mem_ctrl_mp;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic [1:0]  req_in, rw_in, sext_in;
  logic [3:0]  len_in;
  logic [63:0] addr_in, wdata_in;
  logic [7:0]  ram_data_in, f_ram_data_in;
  logic        ram_rw_out, f_ram_rw_out;
  logic [31:0] ram_addr_out, f_ram_addr_out;
  logic [7:0]  ram_data_out, f_ram_data_out;
  logic [1:0]  busy_out, done_out, f_busy_out, f_done_out;
  logic [31:0] rdata_out, f_rdata_out;

  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];
  int nstrobe  = 0;
  int errors   = 0;
  int checks   = 0;
  int ref_last = 1;

  always #5 clk_in = ~clk_in;

  mem_ctrl_mp #(.NUM_PORTS(2), .ADDR_W(32), .ARB_RR(1)) u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .req_in(req_in), .rw_in(rw_in),
    .len_in(len_in), .sext_in(sext_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .ram_data_in(ram_data_in), .ram_rw_out(ram_rw_out), .ram_addr_out(ram_addr_out),
    .ram_data_out(ram_data_out), .busy_out(busy_out), .done_out(done_out), .rdata_out(rdata_out)
  );

  mem_ctrl_mp #(.NUM_PORTS(2), .ADDR_W(32), .ARB_RR(0)) u_fix (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .req_in(req_in), .rw_in(rw_in),
    .len_in(len_in), .sext_in(sext_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .ram_data_in(f_ram_data_in), .ram_rw_out(f_ram_rw_out), .ram_addr_out(f_ram_addr_out),
    .ram_data_out(f_ram_data_out), .busy_out(f_busy_out), .done_out(f_done_out), .rdata_out(f_rdata_out)
  );

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  always @(posedge clk_in) begin
    ram_data_in <= ram_rd(ram_addr_out);
    if (ram_rw_out) begin
      ram[ram_addr_out] = ram_data_out;
      nstrobe++;
    end
  end

  always @(posedge clk_in) f_ram_data_in <= dflt(f_ram_addr_out);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the controller idle; returns at a negedge with it idle again.
  task automatic run_txn(input int p, input bit rw, input bit [1:0] len, input bit sx,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int stall_at, input int stall_len, input int rst_at,
                         output logic [31:0] got);
    int L, c, s0, nwr, explat;
    bit seen, bad;
    logic [31:0] exp;
    L = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    s0 = nstrobe;
    exp = '0;
    got = '0;
    if (!rw) begin
      for (int i = 0; i < L; i++) exp |= 32'(ref_rd(a + 32'(i))) << (8 * i);
      if (sx && L < 4 && exp[8*L-1]) exp |= 32'hFFFF_FFFF << (8 * L);
    end else begin
      nwr = (rst_at >= 0) ? rst_at : L;
      for (int i = 0; i < nwr; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
    end
    explat = (rw ? L : L + 1) + ((stall_at >= 0) ? stall_len : 0);
    rw_in[p]         = rw;
    len_in[2*p +: 2] = len;
    sext_in[p]       = sx;
    addr_in[32*p +: 32]  = a;
    wdata_in[32*p +: 32] = wd;
    req_in    = '0;
    req_in[p] = 1'b1;
    @(posedge clk_in);
    c = 0;
    seen = 1'b0;
    while (!seen && c < 60) begin
      @(negedge clk_in);
      if (c == 0) begin
        chk("busy_e0", busy_out, 64'(1 << p));
        // Later changes to the winner's inputs must not matter.
        addr_in[32*p +: 32]  = $urandom;
        wdata_in[32*p +: 32] = $urandom;
        rw_in[p]   = ~rw;
        len_in[2*p +: 2] = ~len;
        sext_in[p] = ~sx;
        req_in = '0;
      end
      if (c == rst_at) begin
        rst_in = 1'b1;
        #1;
        chk("rst_ctl", {busy_out, done_out, ram_rw_out, ram_data_out}, '0);
        chk("rst_rdata", rdata_out, '0);
        chk("rst_addr", ram_addr_out, '0);
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        ref_last = 1;
        bad = 1'b0;
        repeat (6) begin
          @(negedge clk_in);
          if (done_out !== 2'b00 || ram_rw_out !== 1'b0 || busy_out !== 2'b00) bad = 1'b1;
        end
        chk("rst_quiet", bad, 0);
        chk("rst_strobes", nstrobe - s0, rst_at);
        return;
      end
      if (c == stall_at) rdy_in = 1'b0;
      if (stall_at >= 0 && c == stall_at + stall_len) rdy_in = 1'b1;
      if (rw && stall_at >= 0 && stall_len >= 2 && c == stall_at + 1)
        chk("stall_no_strobe", ram_rw_out, 0);
      if (done_out !== 2'b00) begin
        seen = 1'b1;
        got  = rdata_out;
        chk("latency", c, explat);
        chk("done", done_out, 64'(1 << p));
        chk("busy_done", busy_out, 64'(1 << p));
        chk("rdata", rdata_out, exp);
        chk("strobes", nstrobe - s0, rw ? L : 0);
      end else begin
        c++;
      end
    end
    chk("done_seen", seen, 1);
    rdy_in = 1'b1;
    ref_last = p;
    @(negedge clk_in);
  endtask

  initial begin
    logic [31:0] got;
    int p, L, n, expw, sat, sln;
    bit rw, sx;
    bit [1:0] len;
    logic [31:0] a;

    rst_in = 1'b1; rdy_in = 1'b1; req_in = '0; rw_in = '0; sext_in = '0;
    len_in = '0; addr_in = '0; wdata_in = '0;
    @(posedge clk_in);
    #1;
    chk("reset_ctl", {busy_out, done_out, ram_rw_out, ram_data_out}, '0);
    chk("reset_rdata", rdata_out, '0);
    chk("reset_addr", ram_addr_out, '0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);

    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    ref_mem[32'h100] = 8'h11; ref_mem[32'h101] = 8'h22; ref_mem[32'h102] = 8'h33; ref_mem[32'h103] = 8'h44;
    ram[32'h7] = 8'h80; ref_mem[32'h7] = 8'h80;

    run_txn(0, 1'b0, 2'd2, 1'b0, 32'h100, '0, -1, 0, -1, got);
    chk("word_read", got, 32'h4433_2211);
    run_txn(1, 1'b0, 2'd0, 1'b1, 32'h7, '0, -1, 0, -1, got);
    chk("byte_sext", got, 32'hFFFF_FF80);
    run_txn(1, 1'b0, 2'd0, 1'b0, 32'h7, '0, -1, 0, -1, got);
    chk("byte_zext", got, 32'h0000_0080);
    run_txn(1, 1'b1, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0000_BEEF, -1, 0, -1, got);
    chk("wrap_lo", ram_rd(32'hFFFF_FFFF), 8'hEF);
    chk("wrap_hi", ram_rd(32'h0), 8'hBE);

    run_txn(1, 1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFE_F00D, 2, 3, -1, got);
    run_txn(0, 1'b0, 2'd3, 1'b0, 32'h300, '0, -1, 0, -1, got);
    chk("stall_readback", got, 32'hCAFE_F00D);

    run_txn(0, 1'b1, 2'd2, 1'b0, 32'h400, 32'h1234_5678, -1, 0, 2, got);
    run_txn(1, 1'b0, 2'd2, 1'b0, 32'h400, '0, -1, 0, -1, got);

    for (int k = 0; k < 24; k++) begin
      p   = int'($urandom_range(0, 1));
      rw  = 1'($urandom_range(0, 1));
      len = 2'($urandom_range(0, 3));
      sx  = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                         : 32'h200 + 32'($urandom_range(0, 31));
      L   = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
      sat = -1; sln = 0;
      if (rw && $urandom_range(0, 1) == 1) begin
        sat = int'($urandom_range(0, L - 1));
        sln = int'($urandom_range(2, 3));
      end
      run_txn(p, rw, len, sx, a, $urandom, sat, sln, -1, got);
    end

    rw_in = '0; sext_in = '0; len_in = '0;
    addr_in = {32'h500, 32'h600};
    req_in = 2'b11;
    expw = (ref_last + 1) % 2;
    n = 0;
    for (int k = 0; k < 60 && n < 4; k++) begin
      @(negedge clk_in);
      if (f_done_out !== 2'b00) chk("fixed_grant", f_done_out, 2'b10);
      if (done_out !== 2'b00) begin
        chk("rr_grant", done_out, 64'(1 << expw));
        chk("rr_busy", busy_out, 64'(1 << expw));
        ref_last = expw;
        expw = 1 - expw;
        n++;
      end
    end
    req_in = '0;
    chk("rr_count", n, 4);
    @(negedge clk_in);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
